// File: rtl/comb_split.sv
// comb_split: buffers 64-bit packed words in a small FIFO and emits each word as two
// 32-bit operands, high half (op1) first, then low half (op2) flagged with out_last.
// Optional feature: define COMB_SPLIT_CNT_EN to add the 16-bit word_cnt output that
// counts output transfers.
module comb_split #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] comb,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
`ifdef COMB_SPLIT_CNT_EN
    ,
    output logic [15:0] word_cnt
`endif
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy must represent 0..DEPTH inclusive.
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        StHi = 1'b0,
        StLo = 1'b1
    } phase_e;

    // Storage (not reset) and control state.
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    phase_e        r_phase;
    logic [31:0]   r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    // Handshake and next-state wires.
    logic          w_full;
    logic          w_push;
    logic          w_xfer;
    logic          w_pop;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_remain;
    logic [CW-1:0] w_count_nxt;
    phase_e        w_phase_nxt;
    logic [63:0]   w_head_nxt;
    logic          w_valid_nxt;
    logic          w_last_nxt;
    logic [31:0]   w_data_nxt;

    // Handshakes: in_ready is only a function of occupancy and reset, never of out_ready.
    always_comb begin
        w_full   = (r_count == CW'(DEPTH));
        in_ready = rst & ~w_full;
        w_push   = in_valid & in_ready;
        w_xfer   = r_out_valid & out_ready;
        w_pop    = w_xfer & (r_phase == StLo);
    end

    // Next pointers, occupancy and phase.
    always_comb begin
        w_wptr_nxt  = w_push ? r_wptr + AW'(1) : r_wptr;
        w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;
        // Occupancy after the pop but before the push decides where the next head lives.
        w_remain    = r_count - CW'(w_pop);
        w_count_nxt = w_remain + CW'(w_push);
        w_phase_nxt = r_phase;
        if (w_xfer) begin
            w_phase_nxt = (r_phase == StHi) ? StLo : StHi;
        end
    end

    // Next registered outputs: look ahead at the head word after this edge.
    always_comb begin
        // If nothing remains after the pop, the only possible head is the word being pushed.
        w_head_nxt  = (w_remain == '0) ? comb : r_mem[w_rptr_nxt];
        w_valid_nxt = (w_count_nxt != '0);
        w_last_nxt  = w_valid_nxt & (w_phase_nxt == StLo);
        w_data_nxt  = '0;
        if (w_valid_nxt) begin
            w_data_nxt = (w_phase_nxt == StLo) ? w_head_nxt[31:0] : w_head_nxt[63:32];
        end
    end

    // Control FSM with registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_phase     <= StHi;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_phase     <= w_phase_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
        end
    end

    // Word storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= comb;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

`ifdef COMB_SPLIT_CNT_EN
    logic [15:0] r_word_cnt;

    // Output transfer counter, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule
